// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers in-order
// responses with their PC+4, and flushes on redirect while discarding stale responses.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [31:0]      redirect_addr,
    input  logic             stall,
    output logic             i_mem_req_valid,
    output logic [31:0]      i_mem_req_addr,
    input  logic             i_mem_req_ready,
    input  logic             i_mem_rsp_valid,
    input  logic [31:0]      i_mem_rsp_data,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_ir,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned    PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ir;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [29:0]      fetch_wa_q, fetch_wa_d;
    logic [29:0]      rsp_wa_q, rsp_wa_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W:0]   inflight;
    logic             hs, rsp_ok, push, pop;
    logic             out_valid_d;
    entry_t           head_d, push_entry;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^redirect_addr[1:0];

    // Credits cover both buffered and in-flight words, so a response always has a slot.
    assign inflight        = {1'b0, count_q} + {1'b0, outstanding_q};
    assign i_mem_req_valid = rst && !redirect && (inflight < DEPTH_W);
    assign i_mem_req_addr  = {fetch_wa_q, 2'b00};
    assign count           = count_q;

    assign hs         = i_mem_req_valid && i_mem_req_ready;
    assign rsp_ok     = i_mem_rsp_valid && (outstanding_q != '0);
    assign push       = rsp_ok && (discard_q == '0) && !redirect;
    assign pop        = out_valid && !stall && !redirect;
    assign push_entry = '{pc4: {rsp_wa_q + 30'd1, 2'b00}, ir: i_mem_rsp_data};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        fetch_wa_d    = fetch_wa_q;
        rsp_wa_d      = rsp_wa_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CNT_W'(hs) - CNT_W'(rsp_ok);
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

        if (hs) fetch_wa_d = fetch_wa_q + 30'd1;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rsp_wa_d = rsp_wa_q + 30'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);

        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect) begin
            fetch_wa_d = redirect_addr[31:2];
            rsp_wa_d   = redirect_addr[31:2];
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outstanding_q - CNT_W'(rsp_ok);
        end

        out_valid_d = (count_d != '0);
        if (count_d == '0)
            head_d = '0;
        else if (push && (wr_ptr_q == rd_ptr_d))
            head_d = push_entry;
        else
            head_d = mem[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_wa_q    <= RESET_PC[31:2];
            rsp_wa_q      <= RESET_PC[31:2];
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_ir        <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            fetch_wa_q    <= fetch_wa_d;
            rsp_wa_q      <= rsp_wa_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            out_valid     <= out_valid_d;
            out_pc        <= head_d.pc4;
            out_ir        <= head_d.ir;
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_entry;
    end

    assert property (@(posedge clk) disable iff (!rst) push |-> ({1'b0, count_q} < DEPTH_W));
    assert property (@(posedge clk) disable iff (!rst) i_mem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction prefetch queue between instruction memory and the decode stage, replacing the single-cycle, fixed-latency fetch path. It issues sequential fetch requests over a valid/ready request channel, accepts in-order responses of arbitrary latency, and buffers up to DEPTH instructions with their PC+4. Branch and jump redirects flush the queue and discard stale in-flight responses. Decode stalls hold the head entry.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2; also bounds in-flight requests.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- CNT_W, $clog2(DEPTH+1): width of occupancy and outstanding counters (derived).

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_addr  in  32  new fetch address; bits [1:0] ignored.
- stall  in  1  decode stall; head entry is not consumed.
- i_mem_req_valid  out  1  fetch request valid.
- i_mem_req_addr  out  32  fetch address, word aligned.
- i_mem_req_ready  in  1  memory accepts request.
- i_mem_rsp_valid  in  1  response valid; in request order; no backpressure.
- i_mem_rsp_data  in  32  instruction word.
- out_valid  out  1  head entry valid.
- out_pc  out  32  head entry PC+4.
- out_ir  out  32  head entry instruction.
- count  out  CNT_W  queue occupancy.

## Operation
- State: fetch_pc, circular buffer of DEPTH {pc4, ir} entries, rd_ptr/wr_ptr (log2 DEPTH bits, natural wrap), count, outstanding, discard.
- Request: i_mem_req_valid = !redirect && (count + outstanding < DEPTH); i_mem_req_addr = {fetch_pc[31:2], 2'b00}.
- Request handshake (valid && ready): outstanding +1; fetch_pc += 4, wrapping modulo 2^32.
- Response: outstanding -1. If discard != 0, discard -1 and drop the word. Otherwise push {address+4, data} at wr_ptr. The entry PC is tracked by a response-side pc counter advanced by 4 per pushed word.
- Pop: occurs when out_valid && !stall; rd_ptr +1 and count -1.
- Push and pop in the same cycle: count is unchanged.
- A push into a full queue cannot occur because of credit accounting. An assertion flags it.
- rsp_valid with outstanding == 0 is a protocol error. The response is ignored and an assertion flags it.
- Redirect in cycle N:
  - Queue is emptied; the pop and the push of cycle N are cancelled.
  - fetch_pc and the response pc both load {redirect_addr[31:2], 2'b00}.
  - discard loads outstanding + (handshake ? 1 : 0) - (rsp_valid ? 1 : 0). The handshake term is always 0 because req_valid is low.
  - Redirect has priority over every other event in the same cycle.
- Empty queue: out_valid = 0, out_ir = 32'h0, out_pc = 32'h0.

## Timing
- All outputs except i_mem_req_valid and i_mem_req_addr are driven from registers.
- i_mem_req_valid is combinational from state and redirect.
- Reset (rst low): fetch_pc = RESET_PC, pointers/count/outstanding/discard = 0, out_valid = 0, out_pc = 0, out_ir = 0, count = 0. i_mem_req_valid is forced 0 while rst is low.
- First request is valid in the first cycle after rst deasserts, with address RESET_PC.
- Latency: request accepted in cycle N and response in N+L gives out_valid in N+L+1. There is no response-to-output bypass.
- Sustained throughput is 1 instruction/cycle when L+1 < DEPTH and memory is always ready.
- Redirect in cycle N: out_valid = 0 in N+1; the first request to redirect_addr is issued in N+1.
- Reset asserted mid-operation clears all state immediately (asynchronous). Responses arriving after reset release are not discarded; the system must reset memory together with this block.

## Test plan
- Reset, then ready=1 with fixed 1-cycle memory returning addr^32'hA5A5_0000:
  - Requests go to 0x0, 0x4, 0x8, …
  - out_valid is first high 2 cycles after the first request, with out_pc=0x4 and out_ir=0xA5A5_0000.
  - Thereafter one entry pops per cycle.
- stall held high for 10 cycles, DEPTH=4:
  - count saturates at 4 and req_valid goes low.
  - Head stays at pc4=0x4.
  - On release, entries 0x4, 0x8, 0xC, 0x10 pop in order with no loss or duplication.
- 3-cycle latency memory with 3 requests in flight, redirect to 0x100:
  - The next 3 responses are dropped.
  - First output is out_pc=0x104 carrying the word for 0x100.
- Redirect in the same cycle as rsp_valid and a pop:
  - The response is dropped, discard = outstanding-1, and the queue is empty next cycle.
  - No stale PC is ever output.
- i_mem_req_ready toggled randomly for 1000 cycles, no redirect:
  - Output PCs are strictly sequential (+4).
  - count + outstanding never exceeds DEPTH.
- Reset pulsed low mid-stream with queue partly full:
  - All outputs are 0 in the same cycle.
  - After release, fetch restarts at RESET_PC.
